id_queue: RTL

Parametrised, decoupled instruction-decode stage that replaces the purely combinational decode path between IF and EX. Fetched words and their PCs enter a DEPTH-entry FIFO over a valid/ready handshake. The head is classified as R/I/J/invalid, its fields are extracted and its immediate and jump target are expanded, and the result is held in a registered output stage with its own valid/ready handshake. Supports a synchronous flush for branch/exception redirect.

---
 rtl/id_queue.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/id_queue.sv
// id_queue: FIFO-decoupled decode stage between IF and EX with a registered, decoded output stage.
// Latency: 1 cycle in->out when the FIFO is empty and the output stage is free or draining; otherwise 1 cycle per older entry.
// Backpressure: in_ready = (count != DEPTH), never combinational on out_ready; the output stage holds while out_valid && !out_ready.

`ifndef INST_TYPE_R
`define INST_TYPE_R       2'd0
`define INST_TYPE_I       2'd1
`define INST_TYPE_J       2'd2
`define INST_TYPE_INVALID 2'd3
`endif

module id_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int PC_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_inst,
  input  logic [PC_W-1:0]        in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        out_pc,
  output logic [1:0]             out_inst_type,
  output logic [5:0]             out_opcode,
  output logic [5:0]             out_funct,
  output logic [4:0]             reg_s,
  output logic [4:0]             reg_t,
  output logic [4:0]             reg_d,
  output logic [4:0]             shift,
  output logic [XLEN-1:0]        imm_ext,
  output logic [PC_W-1:0]        jump_target,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Low 28 bits of a PC are replaced by the J-format index; the rest come from pc+4.
  localparam logic [PC_W-1:0] LOW28_MASK = PC_W'(28'hFFF_FFFF);

  // One queued fetch: raw instruction word plus its PC.
  typedef struct packed {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
  } entry_t;

  // Fully decoded instruction as held in the output stage.
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [1:0]      inst_type;
    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      sh;
    logic [XLEN-1:0] imm;
    logic [PC_W-1:0] target;
  } dec_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  dec_t            out_q;

  logic            fifo_empty;
  logic            push;
  logic            load_en;
  logic            pop;
  logic            bypass;
  logic            fifo_wr;
  entry_t          in_entry;
  entry_t          src;
  dec_t            dec;

  // Classify, extract fields and expand immediate/jump target for one entry.
  function automatic dec_t decode(input entry_t e);
    dec_t            d;
    logic [5:0]      op;
    logic [PC_W-1:0] pc4;
    op       = e.inst[31:26];
    d.pc     = e.pc;
    d.opcode = op;
    d.funct  = e.inst[5:0];
    d.rs     = e.inst[25:21];
    d.rt     = e.inst[20:16];
    d.rd     = e.inst[15:11];
    d.sh     = e.inst[10:6];

    if (op == 6'h00)
      d.inst_type = `INST_TYPE_R;
    else if (op == 6'h02 || op == 6'h03)
      d.inst_type = `INST_TYPE_J;
    else if (op inside {6'h01, [6'h04:6'h10], [6'h20:6'h2B]})
      d.inst_type = `INST_TYPE_I;
    else
      d.inst_type = `INST_TYPE_INVALID;

    // Logical ops zero-extend, LUI shifts into the upper half, everything else sign-extends.
    case (op)
      6'h0C, 6'h0D, 6'h0E: d.imm = XLEN'(e.inst[15:0]);
      6'h0F:               d.imm = XLEN'($signed({e.inst[15:0], 16'h0000}));
      default:             d.imm = XLEN'($signed(e.inst[15:0]));
    endcase

    pc4      = e.pc + PC_W'(4);
    d.target = (pc4 & ~LOW28_MASK) | PC_W'({e.inst[25:0], 2'b00});
    return d;
  endfunction

  assign in_ready   = (count != CW'(DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = in_valid && in_ready && !flush;
  assign load_en    = (!out_valid || out_ready) && !flush;
  assign pop        = load_en && !fifo_empty;
  // An empty FIFO with a free output stage lets the incoming word skip storage.
  assign bypass     = load_en && fifo_empty && push;
  assign fifo_wr    = push && !bypass;

  assign in_entry   = '{inst: in_inst, pc: in_pc};
  // Only one decoder: it looks at the head when anything is queued, else at the input.
  assign src        = fifo_empty ? in_entry : mem[rd_ptr];
  assign dec        = decode(src);

  // Entry storage; pointers gate visibility so this needs no reset.
  always_ff @(posedge clk) begin
    if (fifo_wr)
      mem[wr_ptr] <= in_entry;
  end

  // Pointers and occupancy; flush empties the queue ahead of any push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_wr)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({fifo_wr, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Output stage: load on free/draining slot, hold all fields while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid           <= 1'b0;
      out_q               <= '0;
      out_q.inst_type     <= `INST_TYPE_INVALID;
    end else if (flush) begin
      out_valid           <= 1'b0;
    end else if (load_en) begin
      out_valid           <= pop || bypass;
      if (pop || bypass)
        out_q             <= dec;
    end
  end

  assign out_pc        = out_q.pc;
  assign out_inst_type = out_q.inst_type;
  assign out_opcode    = out_q.opcode;
  assign out_funct     = out_q.funct;
  assign reg_s         = out_q.rs;
  assign reg_t         = out_q.rt;
  assign reg_d         = out_q.rd;
  assign shift         = out_q.sh;
  assign imm_ext       = out_q.imm;
  assign jump_target   = out_q.target;

endmodule
